// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b types and fetch-stage constants.
package fetch_stage_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mux_sel;

    localparam lc3b_mux_sel SEL_SEQ  = 2'b00;
    localparam lc3b_mux_sel SEL_BR   = 2'b01;
    localparam lc3b_mux_sel SEL_TRAP = 2'b10;
    localparam lc3b_mux_sel SEL_JMP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    localparam lc3b_word PC_INC = 16'd2;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus the IF/ID hand-off toward decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic     imem_read;
    lc3b_word imem_address;
    logic     imem_resp;
    lc3b_word imem_rdata;
    logic     id_ready;
    logic     if_valid;
    lc3b_word if_ir;
    lc3b_word if_pc;
    lc3b_word if_pc_plus2;

    modport master (
        output imem_read, imem_address, if_valid, if_ir, if_pc, if_pc_plus2,
        input  imem_resp, imem_rdata, id_ready
    );

    modport slave (
        input  imem_read, imem_address, if_valid, if_ir, if_pc, if_pc_plus2,
        output imem_resp, imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_pc_mux.sv
// Next-PC select: sequential or one of the resolved redirect targets, halfword aligned.
module fetch_pc_mux
    import fetch_stage_pkg::*;
(
    input  lc3b_mux_sel sel,
    input  lc3b_word    pc_plus2,
    input  lc3b_word    br_target,
    input  lc3b_word    trap_target,
    input  lc3b_word    jmp_target,
    output lc3b_word    next_pc
);
    lc3b_word sel_word;

    // Four-way target select
    always_comb begin
        sel_word = pc_plus2;
        unique case (sel)
            SEL_SEQ:  sel_word = pc_plus2;
            SEL_BR:   sel_word = br_target;
            SEL_TRAP: sel_word = trap_target;
            SEL_JMP:  sel_word = jmp_target;
            default:  sel_word = pc_plus2;
        endcase
    end

    // Instructions are halfword aligned, so bit 0 is always cleared.
    assign next_pc = sel_word & 16'hFFFE;
endmodule

// File: rtl/fetch_stage.sv
// LC-3b IF stage: PC, imem request FSM, one-entry skid buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  lc3b_mux_sel     pc_mux_sel,
    input  logic            redirect,
    input  lc3b_word        br_target,
    input  lc3b_word        trap_target,
    input  lc3b_word        jmp_target,
    fetch_stage_if.master   bus
);
    fetch_state_t state, state_next;
    lc3b_word     pc, pc_plus2, next_pc, drain_addr;
    lc3b_mux_sel  sel_eff;
    logic         take_redirect;
    logic         skid_valid;
    lc3b_word     skid_ir, skid_pc;

    assign take_redirect = redirect && (pc_mux_sel != SEL_SEQ);
    assign sel_eff       = take_redirect ? pc_mux_sel : SEL_SEQ;
    assign pc_plus2      = pc + PC_INC;

    fetch_pc_mux u_pc_mux (
        .sel         (sel_eff),
        .pc_plus2    (pc_plus2),
        .br_target   (br_target),
        .trap_target (trap_target),
        .jmp_target  (jmp_target),
        .next_pc     (next_pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and imem request outputs; DRAIN keeps presenting the stale
    // address because an issued read cannot be withdrawn.
    always_comb begin
        state_next       = state;
        bus.imem_read    = 1'b0;
        bus.imem_address = pc;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                bus.imem_read = 1'b1;
                if (take_redirect)
                    state_next = bus.imem_resp ? REQ : DRAIN;
                else if (bus.imem_resp && bus.if_valid && !bus.id_ready)
                    state_next = HOLD;
            end
            HOLD: begin
                if (take_redirect || bus.id_ready) state_next = REQ;
            end
            DRAIN: begin
                bus.imem_read    = 1'b1;
                bus.imem_address = drain_addr;
                if (bus.imem_resp) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // PC update; the outstanding address is latched when a redirect orphans it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            if (take_redirect || (state == REQ && bus.imem_resp))
                pc <= next_pc;
            if (state == REQ && take_redirect && !bus.imem_resp)
                drain_addr <= pc;
        end
    end

    // IF/ID register and skid buffer; redirect flushes both.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.if_valid    <= 1'b0;
            bus.if_ir       <= '0;
            bus.if_pc       <= '0;
            bus.if_pc_plus2 <= '0;
            skid_valid      <= 1'b0;
            skid_ir         <= '0;
            skid_pc         <= '0;
        end else if (take_redirect) begin
            bus.if_valid <= 1'b0;
            skid_valid   <= 1'b0;
        end else if (state == REQ && bus.imem_resp) begin
            if (!bus.if_valid || bus.id_ready) begin
                bus.if_valid    <= 1'b1;
                bus.if_ir       <= bus.imem_rdata;
                bus.if_pc       <= pc;
                bus.if_pc_plus2 <= pc_plus2;
            end else begin
                skid_valid <= 1'b1;
                skid_ir    <= bus.imem_rdata;
                skid_pc    <= pc;
            end
        end else if (state == HOLD && bus.id_ready) begin
            bus.if_valid    <= skid_valid;
            bus.if_ir       <= skid_ir;
            bus.if_pc       <= skid_pc;
            bus.if_pc_plus2 <= skid_pc + PC_INC;
            skid_valid      <= 1'b0;
        end else if (bus.if_valid && bus.id_ready) begin
            bus.if_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/skid, redirects, wrap, reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    lc3b_mux_sel pc_mux_sel;
    logic        redirect;
    logic        redirect_w;
    lc3b_word    br_target, trap_target, jmp_target;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_stage_if bus ();
    fetch_stage_if bus_w ();

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_mux_sel  (pc_mux_sel),
        .redirect    (redirect),
        .br_target   (br_target),
        .trap_target (trap_target),
        .jmp_target  (jmp_target),
        .bus         (bus)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_mux_sel  (pc_mux_sel),
        .redirect    (redirect_w),
        .br_target   (br_target),
        .trap_target (trap_target),
        .jmp_target  (jmp_target),
        .bus         (bus_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; pc_mux_sel = SEL_SEQ; redirect = 1'b0; redirect_w = 1'b0;
        br_target = '0; trap_target = '0; jmp_target = '0;
        bus.imem_resp = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
        bus_w.imem_resp = 1'b0; bus_w.imem_rdata = '0; bus_w.id_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("rst_read",  {15'd0, bus.imem_read}, 16'd0);
        chk("rst_ir",    bus.if_ir, 16'h0000);
        chk("rst_pc",    bus.if_pc, 16'h0000);
        chk("rst_pc2",   bus.if_pc_plus2, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk("post_rst_read", {15'd0, bus.imem_read}, 16'd1);
        chk("t1_addr0", bus.imem_address, 16'h0000);

        // 1: back-to-back single-cycle responses
        bus.id_ready = 1'b1; bus.imem_resp = 1'b1; bus.imem_rdata = 16'hA000;
        tick();
        chk("t1_valid0", {15'd0, bus.if_valid}, 16'd1);
        chk("t1_ir0",    bus.if_ir, 16'hA000);
        chk("t1_pc0",    bus.if_pc, 16'h0000);
        chk("t1_pc2_0",  bus.if_pc_plus2, 16'h0002);
        chk("t1_addr2",  bus.imem_address, 16'h0002);
        bus.imem_rdata = 16'hA002;
        tick();
        chk("t1_ir1",    bus.if_ir, 16'hA002);
        chk("t1_pc1",    bus.if_pc, 16'h0002);
        chk("t1_addr4",  bus.imem_address, 16'h0004);
        bus.imem_resp = 1'b0;
        tick();
        chk("t1_consumed", {15'd0, bus.if_valid}, 16'd0);

        // 2: decode stalls across two responses
        bus.id_ready = 1'b0; bus.imem_resp = 1'b1; bus.imem_rdata = 16'hB004;
        tick();
        chk("t2_ir0",   bus.if_ir, 16'hB004);
        chk("t2_addr6", bus.imem_address, 16'h0006);
        bus.imem_rdata = 16'hB006;
        tick();
        bus.imem_resp = 1'b0;
        #1;
        chk("t2_hold_read", {15'd0, bus.imem_read}, 16'd0);
        chk("t2_hold_ir",   bus.if_ir, 16'hB004);
        chk("t2_hold_vld",  {15'd0, bus.if_valid}, 16'd1);
        bus.id_ready = 1'b1;
        tick();
        chk("t2_skid_ir",   bus.if_ir, 16'hB006);
        chk("t2_skid_pc",   bus.if_pc, 16'h0006);
        chk("t2_skid_pc2",  bus.if_pc_plus2, 16'h0008);
        chk("t2_read",      {15'd0, bus.imem_read}, 16'd1);
        chk("t2_addr8",     bus.imem_address, 16'h0008);
        tick();
        chk("t2_consumed",  {15'd0, bus.if_valid}, 16'd0);

        // 3: branch redirect while a read is outstanding
        redirect = 1'b1; pc_mux_sel = SEL_BR; br_target = 16'h3001;
        tick();
        redirect = 1'b0; pc_mux_sel = SEL_SEQ;
        #1;
        chk("t3_drain_read", {15'd0, bus.imem_read}, 16'd1);
        chk("t3_drain_addr", bus.imem_address, 16'h0008);
        tick();
        chk("t3_drain_hold", bus.imem_address, 16'h0008);
        bus.imem_resp = 1'b1; bus.imem_rdata = 16'hDEAD;
        tick();
        bus.imem_resp = 1'b0;
        #1;
        chk("t3_dropped", {15'd0, bus.if_valid}, 16'd0);
        chk("t3_addr",    bus.imem_address, 16'h3000);

        // 4: jmp redirect coincident with a response
        bus.id_ready = 1'b0; bus.imem_resp = 1'b1; bus.imem_rdata = 16'hC000;
        tick();
        chk("t4_pre_valid", {15'd0, bus.if_valid}, 16'd1);
        chk("t4_pre_addr",  bus.imem_address, 16'h3002);
        bus.imem_rdata = 16'hC002; redirect = 1'b1; pc_mux_sel = SEL_JMP; jmp_target = 16'h4000;
        tick();
        redirect = 1'b0; pc_mux_sel = SEL_SEQ; bus.imem_resp = 1'b0;
        #1;
        chk("t4_flush",  {15'd0, bus.if_valid}, 16'd0);
        chk("t4_read",   {15'd0, bus.imem_read}, 16'd1);
        chk("t4_addr",   bus.imem_address, 16'h4000);

        // 6: reset while draining; late response must be ignored
        redirect = 1'b1; pc_mux_sel = SEL_TRAP; trap_target = 16'h0200;
        tick();
        redirect = 1'b0; pc_mux_sel = SEL_SEQ;
        #1;
        chk("t6_drain_addr", bus.imem_address, 16'h4000);
        reset_n = 1'b0;
        tick();
        chk("t6_rst_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("t6_rst_read",  {15'd0, bus.imem_read}, 16'd0);
        chk("t6_rst_ir",    bus.if_ir, 16'h0000);
        chk("t6_rst_pc",    bus.if_pc, 16'h0000);
        chk("t6_rst_pc2",   bus.if_pc_plus2, 16'h0000);
        reset_n = 1'b1; bus.imem_resp = 1'b1; bus.imem_rdata = 16'hBEEF;
        tick();
        bus.imem_resp = 1'b0;
        #1;
        chk("t6_late_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("t6_late_addr",  bus.imem_address, 16'h0000);
        chk("t6_late_read",  {15'd0, bus.imem_read}, 16'd1);

        // 5: PC wrap from FFFE
        chk("t5_addr_fffe", bus_w.imem_address, 16'hFFFE);
        bus_w.id_ready = 1'b1; bus_w.imem_resp = 1'b1; bus_w.imem_rdata = 16'h1234;
        tick();
        chk("t5_ir",      bus_w.if_ir, 16'h1234);
        chk("t5_pc",      bus_w.if_pc, 16'hFFFE);
        chk("t5_pc2",     bus_w.if_pc_plus2, 16'h0000);
        chk("t5_addr0",   bus_w.imem_address, 16'h0000);
        bus_w.imem_rdata = 16'h5678;
        tick();
        bus_w.imem_resp = 1'b0;
        chk("t5_pc_b",    bus_w.if_pc, 16'h0000);
        chk("t5_pc2_b",   bus_w.if_pc_plus2, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
